// File: rtl/dnn_mlp_engine.sv
// Time-multiplexed two-layer perceptron built around one shared signed MAC.
// Jobs enter and results leave over valid/ready handshakes.
module dnn_mlp_engine #(
   parameter int N_IN  = 4,
   parameter int N_HID = 4,
   parameter int N_OUT = 2,
   parameter int DW    = 5,
   parameter int RELU  = 1,
   localparam int HW   = 2*DW+$clog2(N_IN),
   localparam int OW   = HW+DW+$clog2(N_HID)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N_IN*DW-1:0]      x_flat,
   input  logic [N_IN*N_HID*DW-1:0] w1_flat,
   input  logic [N_HID*N_OUT*DW-1:0] w2_flat,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N_OUT*OW-1:0]     y_flat,
   output logic                    busy
);

   localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int HC = (N_HID > 1) ? $clog2(N_HID) : 1;
   localparam int OC = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

   state_t                      state_q, state_d;
   logic [N_IN*DW-1:0]          x_q, x_d;
   logic [N_IN*N_HID*DW-1:0]    w1_q, w1_d;
   logic [N_HID*N_OUT*DW-1:0]   w2_q, w2_d;
   logic [N_HID*HW-1:0]         hid_q, hid_d;
   logic [N_OUT*OW-1:0]         y_q, y_d;
   logic signed [OW-1:0]        acc_q, acc_d;
   logic [IW-1:0]               i_q, i_d;
   logic [HC-1:0]               h_q, h_d;
   logic [OC-1:0]               o_q, o_d;

   logic signed [DW-1:0]        xs;
   logic signed [DW-1:0]        ws;
   logic signed [HW-1:0]        as;
   logic signed [HW+DW-1:0]     prod;
   logic signed [OW-1:0]        sum;
   logic [HW-1:0]               act;

   // Operand mux: layer 1 feeds x/w1, layer 2 feeds hidden/w2.
   always_comb begin
      xs = x_q[i_q*DW +: DW];
      as = HW'(xs);
      ws = w1_q[(h_q*N_IN+i_q)*DW +: DW];
      if (state_q == L2) begin
         as = hid_q[h_q*HW +: HW];
         ws = w2_q[(o_q*N_HID+h_q)*DW +: DW];
      end
      prod = (HW+DW)'(as) * (HW+DW)'(ws);
      sum  = acc_q + OW'(prod);
      act  = sum[HW-1:0];
      if (RELU != 0 && sum[OW-1]) act = '0;
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      w1_d    = w1_q;
      w2_d    = w2_q;
      hid_d   = hid_q;
      y_d     = y_q;
      acc_d   = acc_q;
      i_d     = i_q;
      h_d     = h_q;
      o_d     = o_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d     = x_flat;
               w1_d    = w1_flat;
               w2_d    = w2_flat;
               acc_d   = '0;
               i_d     = '0;
               h_d     = '0;
               o_d     = '0;
               state_d = L1;
            end
         end
         L1: begin
            if (i_q == IW'(N_IN-1)) begin
               hid_d[h_q*HW +: HW] = act;
               acc_d = '0;
               i_d   = '0;
               if (h_q == HC'(N_HID-1)) begin
                  h_d     = '0;
                  o_d     = '0;
                  state_d = L2;
               end else begin
                  h_d = h_q + HC'(1);
               end
            end else begin
               acc_d = sum;
               i_d   = i_q + IW'(1);
            end
         end
         L2: begin
            if (h_q == HC'(N_HID-1)) begin
               y_d[o_q*OW +: OW] = sum;
               acc_d = '0;
               h_d   = '0;
               if (o_q == OC'(N_OUT-1)) state_d = DONE;
               else o_d = o_q + OC'(1);
            end else begin
               acc_d = sum;
               h_d   = h_q + HC'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         w1_q    <= '0;
         w2_q    <= '0;
         hid_q   <= '0;
         y_q     <= '0;
         acc_q   <= '0;
         i_q     <= '0;
         h_q     <= '0;
         o_q     <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         w1_q    <= w1_d;
         w2_q    <= w2_d;
         hid_q   <= hid_d;
         y_q     <= y_d;
         acc_q   <= acc_d;
         i_q     <= i_d;
         h_q     <= h_d;
         o_q     <= o_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == L1) || (state_q == L2);
   assign y_flat    = y_q;

endmodule

// File: tb/tb_dnn_mlp_engine.sv
// Bench for dnn_mlp_engine: table of jobs plus handshake/reset sequences,
// checked against a scoreboard queue for both ReLU settings.
module tb_dnn_mlp_engine;

   localparam int OW = 19;

   typedef struct {
      logic [19:0] x;
      logic [79:0] w1;
      logic [39:0] w2;
      int          y0r;
      int          y1r;
      int          y0n;
      int          y1n;
   } vec_t;

   logic        clk = 0;
   logic        rst_n = 0;
   logic        in_valid = 0;
   logic        out_ready = 0;
   logic [19:0] x_flat = '0;
   logic [79:0] w1_flat = '0;
   logic [39:0] w2_flat = '0;
   logic        in_ready, out_valid, busy;
   logic        in_ready0, out_valid0, busy0;
   logic [2*OW-1:0] y_r, y_n;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t sb[$];
   vec_t tbl[7];

   always #5 clk = ~clk;

   dnn_mlp_engine #(.RELU(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .x_flat(x_flat), .w1_flat(w1_flat), .w2_flat(w2_flat),
      .out_valid(out_valid), .out_ready(out_ready),
      .y_flat(y_r), .busy(busy)
   );

   dnn_mlp_engine #(.RELU(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready0),
      .x_flat(x_flat), .w1_flat(w1_flat), .w2_flat(w2_flat),
      .out_valid(out_valid0), .out_ready(out_ready),
      .y_flat(y_n), .busy(busy0)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int sx(input logic [4:0] v);
      logic signed [4:0] s;
      s = v;
      return int'(s);
   endfunction

   function automatic vec_t model(input logic [19:0] x, input logic [79:0] w1,
                                  input logic [39:0] w2);
      vec_t r;
      int hr[4];
      int hn[4];
      int yr[2];
      int yn[2];
      r.x = x; r.w1 = w1; r.w2 = w2;
      for (int h = 0; h < 4; h++) begin
         int a = 0;
         for (int i = 0; i < 4; i++)
            a += sx(x[i*5 +: 5]) * sx(w1[(h*4+i)*5 +: 5]);
         hn[h] = a;
         hr[h] = (a < 0) ? 0 : a;
      end
      for (int o = 0; o < 2; o++) begin
         yr[o] = 0; yn[o] = 0;
         for (int h = 0; h < 4; h++) begin
            yr[o] += hr[h] * sx(w2[(o*4+h)*5 +: 5]);
            yn[o] += hn[h] * sx(w2[(o*4+h)*5 +: 5]);
         end
      end
      r.y0r = yr[0]; r.y1r = yr[1]; r.y0n = yn[0]; r.y1n = yn[1];
      return r;
   endfunction

   function automatic int yv(input logic [2*OW-1:0] y, input int o);
      logic signed [OW-1:0] s;
      s = y[o*OW +: OW];
      return int'(s);
   endfunction

   task automatic check_reset(input string nm);
      chk({nm, "_out_valid"}, out_valid, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_in_ready"}, in_ready, 1);
      chk({nm, "_y"}, (y_r == '0) && (y_n == '0), 1);
   endtask

   task automatic accept(input vec_t v, input bit push);
      int t = 0;
      @(negedge clk);
      in_valid = 1;
      x_flat = v.x; w1_flat = v.w1; w2_flat = v.w2;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("accept_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      if (push) sb.push_back(v);
      in_valid = 0;
      x_flat = 20'($urandom);
      w1_flat = {$urandom, $urandom, 16'($urandom)};
      w2_flat = {8'($urandom), $urandom};
   endtask

   task automatic await_done(input string nm);
      int lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({nm, "_latency"}, lat, 24);
      chk({nm, "_relu0_valid"}, out_valid0, 1);
   endtask

   task automatic pop_check(input string nm);
      vec_t e;
      if (sb.size() == 0) begin
         chk({nm, "_sb_empty"}, 0, 1);
      end else begin
         e = sb.pop_front();
         chk({nm, "_y0_relu"}, yv(y_r, 0), e.y0r);
         chk({nm, "_y1_relu"}, yv(y_r, 1), e.y1r);
         chk({nm, "_y0_lin"}, yv(y_n, 0), e.y0n);
         chk({nm, "_y1_lin"}, yv(y_n, 1), e.y1n);
      end
   endtask

   task automatic handshake(input string nm);
      @(negedge clk);
      out_ready = 1;
      @(posedge clk);
      #1;
      out_ready = 0;
      chk({nm, "_hs_out_valid"}, out_valid, 0);
      chk({nm, "_hs_in_ready"}, in_ready, 1);
   endtask

   initial begin
      vec_t a, b;
      tbl[0] = '{20'({4{5'd1}}), 80'({16{5'd1}}), 40'({8{5'd1}}),
                 16, 16, 16, 16};
      tbl[1] = '{20'({4{5'h10}}), 80'({16{5'h10}}), 40'({8{5'h10}}),
                 -65536, -65536, -65536, -65536};
      tbl[2] = '{20'({4{5'd1}}), 80'({16{5'h1f}}), 40'({8{5'd15}}),
                 0, 0, -240, -240};
      for (int k = 3; k < 7; k++)
         tbl[k] = model(20'($urandom),
                        {$urandom, $urandom, 16'($urandom)},
                        {8'($urandom), $urandom});

      #12;
      check_reset("reset");
      @(negedge clk);
      rst_n = 1;

      for (int k = 0; k < 7; k++) begin
         accept(tbl[k], 1);
         chk($sformatf("job%0d_busy", k), busy, 1);
         await_done($sformatf("job%0d", k));
         pop_check($sformatf("job%0d", k));
         handshake($sformatf("job%0d", k));
      end

      // Backpressure in DONE while a new job waits on in_valid
      a = tbl[0];
      b = tbl[2];
      accept(a, 1);
      await_done("bp");
      @(negedge clk);
      in_valid = 1;
      x_flat = b.x; w1_flat = b.w1; w2_flat = b.w2;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_y0_stable", yv(y_r, 0), a.y0r);
      end
      pop_check("bp");
      @(negedge clk);
      out_ready = 1;
      @(posedge clk);
      #1;
      out_ready = 0;
      chk("bp_release_in_ready", in_ready, 1);
      chk("bp_release_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      sb.push_back(b);
      in_valid = 0;
      x_flat = '0;
      chk("bp_next_busy", busy, 1);
      await_done("bp_next");
      pop_check("bp_next");
      handshake("bp_next");

      // Reset mid-L1, then a fresh job whose inputs change after accept
      accept(tbl[1], 0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 0;
      #1;
      check_reset("midrst");
      chk("midrst_relu0_valid", out_valid0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      accept(tbl[0], 1);
      await_done("after_rst");
      pop_check("after_rst");
      handshake("after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
